// File: rtl/obi_rready_fifo_pkg.sv
// Shared OBI configuration, channel/struct types and defaults for the rready adapter.
// Types are fixed-width instances of the default OBI configuration.
package obi_rready_fifo_pkg;

    localparam int unsigned ObiRReadyFifoDefaultDepth = 2;

    typedef struct packed {
        bit          UseRReady;
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        UseRReady: 1'b0,
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   4
    };

    function automatic obi_cfg_t obi_cfg_set_rready(obi_cfg_t cfg, bit use_rready);
        obi_cfg_t c;
        c           = cfg;
        c.UseRReady = use_rready;
        return c;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_sbr_req_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_sbr_rsp_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_mgr_req_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_mgr_rsp_t;

endpackage

// File: rtl/obi_rready_fifo_fifo.sv
// Small FIFO (fifo_v3 interface) buffering R-channel beats; optional fall-through
// presents data_i on data_o when empty and skips storage if popped in the same cycle.
module obi_rready_fifo_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 2,
    parameter type         DATA_TYPE    = logic
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     flush_i,
    input  logic     testmode_i,
    output logic     full_o,
    output logic     empty_o,
    input  DATA_TYPE data_i,
    input  logic     push_i,
    output DATA_TYPE data_o,
    input  logic     pop_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    DATA_TYPE        r_mem [DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_cnt;
    logic            w_ft;
    logic            w_push;
    logic            w_pop;
    logic            w_unused_testmode;

    function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_unused_testmode = testmode_i;

    assign full_o  = (r_cnt == CntW'(DEPTH));
    assign w_ft    = FALL_THROUGH && (r_cnt == '0) && push_i;
    assign empty_o = (r_cnt == '0) && !w_ft;
    assign data_o  = w_ft ? data_i : r_mem[r_rd_ptr];
    // A fall-through beat taken in the same cycle is neither stored nor popped.
    assign w_push  = push_i && !full_o && !(w_ft && pop_i);
    assign w_pop   = pop_i && !empty_o && !w_ft;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/obi_rready_fifo.sv
// Adapts an rready-capable OBI subordinate port to a downstream port without rready.
// Define OBI_RREADY_FIFO_BYPASS_EN for a fall-through response path (0 latency when rready=1).
module obi_rready_fifo
    import obi_rready_fifo_pkg::*;
#(
    parameter obi_cfg_t    SbrCfg    = obi_cfg_set_rready(ObiDefaultConfig, 1'b1),
    parameter obi_cfg_t    MgrCfg    = obi_cfg_set_rready(SbrCfg, 1'b0),
    parameter type         sbr_req_t = obi_sbr_req_t,
    parameter type         sbr_rsp_t = obi_sbr_rsp_t,
    parameter type         mgr_req_t = obi_mgr_req_t,
    parameter type         mgr_rsp_t = obi_mgr_rsp_t,
    parameter int unsigned Depth     = ObiRReadyFifoDefaultDepth
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  sbr_req_t sbr_req_i,
    output sbr_rsp_t sbr_rsp_o,
    output mgr_req_t mgr_req_o,
    input  mgr_rsp_t mgr_rsp_i
);

    localparam int unsigned CntW   = $clog2(Depth + 1);
    localparam int unsigned RDataW = SbrCfg.DataWidth;
    localparam int unsigned RIdW   = SbrCfg.IdWidth;
`ifdef OBI_RREADY_FIFO_BYPASS_EN
    localparam bit FallThrough = 1'b1;
`else
    localparam bit FallThrough = 1'b0;
`endif

    typedef struct packed {
        logic [RDataW-1:0] rdata;
        logic [RIdW-1:0]   rid;
        logic              err;
    } rsp_chan_t;

    if (!SbrCfg.UseRReady) begin : g_err_sbr_rready
        $error("obi_rready_fifo: SbrCfg must use rready");
    end
    if (MgrCfg.UseRReady) begin : g_err_mgr_rready
        $error("obi_rready_fifo: MgrCfg must not use rready");
    end
    if (Depth < 1) begin : g_err_depth
        $error("obi_rready_fifo: Depth must be at least 1");
    end
    if ((SbrCfg.AddrWidth != MgrCfg.AddrWidth) || (SbrCfg.DataWidth != MgrCfg.DataWidth) ||
        (SbrCfg.IdWidth != MgrCfg.IdWidth)) begin : g_err_widths
        $error("obi_rready_fifo: A/R field widths differ between configs");
    end

    logic [CntW-1:0] r_cnt_q;
    logic            w_credit;
    logic            w_dn_hs;
    logic            w_retire;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    rsp_chan_t       w_push_data;
    rsp_chan_t       w_head;

    // Credit only looks at the registered count, so rready never reaches gnt.
    assign w_credit = (r_cnt_q < CntW'(Depth));
    assign w_dn_hs  = sbr_req_i.req & w_credit & mgr_rsp_i.gnt;
    assign w_retire = ~w_fifo_empty & sbr_req_i.rready;

    always_comb begin
        mgr_req_o     = '0;
        mgr_req_o.req = sbr_req_i.req & w_credit;
        mgr_req_o.a   = sbr_req_i.a;
    end

    always_comb begin
        sbr_rsp_o         = '0;
        sbr_rsp_o.gnt     = mgr_rsp_i.gnt & w_credit;
        sbr_rsp_o.rvalid  = ~w_fifo_empty;
        sbr_rsp_o.r.rdata = w_head.rdata;
        sbr_rsp_o.r.rid   = w_head.rid;
        sbr_rsp_o.r.err   = w_head.err;
    end

    assign w_push_data = '{rdata: mgr_rsp_i.r.rdata, rid: mgr_rsp_i.r.rid, err: mgr_rsp_i.r.err};

    // Counts granted-but-not-retired transactions, in flight or buffered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt_q <= '0;
        end else if (w_dn_hs && !w_retire) begin
            r_cnt_q <= r_cnt_q + CntW'(1);
        end else if (!w_dn_hs && w_retire) begin
            r_cnt_q <= r_cnt_q - CntW'(1);
        end
    end

    obi_rready_fifo_fifo #(
        .FALL_THROUGH (FallThrough),
        .DEPTH        (Depth),
        .DATA_TYPE    (rsp_chan_t)
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (w_fifo_full),
        .empty_o    (w_fifo_empty),
        .data_i     (w_push_data),
        .push_i     (mgr_rsp_i.rvalid),
        .data_o     (w_head),
        .pop_i      (w_retire)
    );

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mgr_rsp_i.rvalid && w_fifo_full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_retire && w_fifo_empty));

endmodule

// File: tb/tb_obi_rready_fifo.sv
// Bench for obi_rready_fifo: queue-based reference model with a per-cycle compare
// plus directed scenarios (single read, backpressure, stability, overlap, reset, random).
module tb_obi_rready_fifo;
    import obi_rready_fifo_pkg::*;

    localparam int DEPTH = 2;
`ifdef OBI_RREADY_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    obi_sbr_req_t sbr_req;
    obi_sbr_rsp_t sbr_rsp;
    obi_mgr_req_t mgr_req;
    obi_mgr_rsp_t mgr_rsp;

    logic        dn_gnt;
    logic        dn_rvalid_drv;
    obi_r_chan_t dn_r_drv;

    bit          dn_v;
    obi_r_chan_t dn_r;
    obi_r_chan_t q[$];
    int          cnt_m;
    int          n_issued;
    int          n_retired;
    logic [31:0] mem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mgr_rsp = '{r: dn_r_drv, gnt: dn_gnt, rvalid: dn_rvalid_drv};

    obi_rready_fifo #(
        .Depth (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .sbr_req_i (sbr_req),
        .sbr_rsp_o (sbr_rsp),
        .mgr_req_o (mgr_req),
        .mgr_rsp_i (mgr_rsp)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Downstream SRAM: a response appears exactly one cycle after each handshake.
    initial begin
        dn_rvalid_drv = 1'b0;
        dn_r_drv      = '0;
        forever begin
            @(posedge clk);
            #1;
            dn_rvalid_drv = dn_v;
            dn_r_drv      = dn_v ? dn_r : '0;
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        forever begin
            bit          cr;
            bit          ev;
            bit          consumed;
            obi_r_chan_t er;
            @(negedge clk);
            if (!rst_n) begin
                total++;
                if (sbr_rsp.rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_rvalid: got=%0h", sbr_rsp.rvalid);
                end
                q.delete();
                cnt_m = 0;
                dn_v  = 1'b0;
                for (int i = 0; i < 16; i++) mem[i] = 32'hCAFE0000 + i;
            end else begin
                cr = (cnt_m < DEPTH);
                total++;
                if (mgr_req.req !== (sbr_req.req & cr)) begin
                    bad++;
                    $display("FAIL mgr_req: got=%0h want=%0h", mgr_req.req, sbr_req.req & cr);
                end
                total++;
                if (mgr_req.a !== sbr_req.a) begin
                    bad++;
                    $display("FAIL mgr_a: got=%0h want=%0h", mgr_req.a, sbr_req.a);
                end
                total++;
                if (sbr_rsp.gnt !== (dn_gnt & cr)) begin
                    bad++;
                    $display("FAIL sbr_gnt: got=%0h want=%0h", sbr_rsp.gnt, dn_gnt & cr);
                end
                ev = (q.size() > 0);
                er = ev ? q[0] : '0;
                if (BYP && !ev && mgr_rsp.rvalid) begin
                    ev = 1'b1;
                    er = mgr_rsp.r;
                end
                total++;
                if (sbr_rsp.rvalid !== ev) begin
                    bad++;
                    $display("FAIL sbr_rvalid: got=%0h want=%0h", sbr_rsp.rvalid, ev);
                end
                if (ev) begin
                    total++;
                    if (sbr_rsp.r !== er) begin
                        bad++;
                        $display("FAIL sbr_r: got=%0h want=%0h", sbr_rsp.r, er);
                    end
                end
                consumed = 1'b0;
                if (sbr_rsp.rvalid && sbr_req.rready) n_retired++;
                if (ev && sbr_req.rready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else consumed = 1'b1;
                    cnt_m--;
                end
                if (mgr_rsp.rvalid && !consumed) q.push_back(mgr_rsp.r);
                if (sbr_req.req && cr && dn_gnt) begin
                    cnt_m++;
                    n_issued++;
                    dn_v       = 1'b1;
                    dn_r.rid   = sbr_req.a.aid;
                    dn_r.err   = 1'b0;
                    if (sbr_req.a.we) begin
                        mem[sbr_req.a.addr[3:0]] = sbr_req.a.wdata;
                        dn_r.rdata = '0;
                    end else begin
                        dn_r.rdata = mem[sbr_req.a.addr[3:0]];
                    end
                end else begin
                    dn_v = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] id, input bit rr, input bit g);
        @(posedge clk);
        #1;
        sbr_req.req     = req;
        sbr_req.a.we    = we;
        sbr_req.a.be    = 4'hF;
        sbr_req.a.addr  = addr;
        sbr_req.a.wdata = wd;
        sbr_req.a.aid   = id;
        sbr_req.rready  = rr;
        dn_gnt          = g;
    endtask

    initial begin
        obi_r_chan_t got_r;
        bit          got_v;
        logic [3:0]  rid_ctr;
        rst_n     = 1'b0;
        sbr_req   = '0;
        dn_gnt    = 1'b0;
        n_issued  = 0;
        n_retired = 0;
        cnt_m     = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        dn_gnt = 1'b1;
        #2;
        chk("reset_rvalid", 128'(sbr_rsp.rvalid), 128'(1'b0));
        chk("reset_gnt_follows", 128'(sbr_rsp.gnt), 128'(1'b1));
        chk("reset_req_low", 128'(mgr_req.req), 128'(1'b0));

        // T1: single read of address 1, rid 3
        cyc(1, 0, 32'd1, 32'd0, 4'd3, 1, 1); #2;
        chk("t1_req_fwd", 128'(mgr_req.req), 128'(1'b1));
        chk("t1_gnt", 128'(sbr_rsp.gnt), 128'(1'b1));
        got_v = 1'b0;
        got_r = '0;
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 1, 1); #2;
        chk("t1_c1_rvalid", 128'(sbr_rsp.rvalid), 128'(BYP));
        if (sbr_rsp.rvalid) begin got_v = 1'b1; got_r = sbr_rsp.r; end
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 1, 1); #2;
        chk("t1_c2_rvalid", 128'(sbr_rsp.rvalid), 128'(!BYP));
        if (sbr_rsp.rvalid) begin got_v = 1'b1; got_r = sbr_rsp.r; end
        chk("t1_seen", 128'(got_v), 128'(1'b1));
        chk("t1_rdata", 128'(got_r.rdata), 128'(32'hCAFE0001));
        chk("t1_rid", 128'(got_r.rid), 128'(4'd3));
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 1, 1); #2;
        chk("t1_model_cnt", 128'(cnt_m), 128'(0));

        // T2/T3: backpressure, three writes with rready low
        cyc(1, 1, 32'd4, 32'h11, 4'd0, 0, 1); #2;
        chk("t2_gnt_w0", 128'(sbr_rsp.gnt), 128'(1'b1));
        cyc(1, 1, 32'd5, 32'h22, 4'd1, 0, 1); #2;
        chk("t2_gnt_w1", 128'(sbr_rsp.gnt), 128'(1'b1));
        cyc(1, 1, 32'd6, 32'h33, 4'd2, 0, 1); #2;
        chk("t2_gnt_w2_blocked", 128'(sbr_rsp.gnt), 128'(1'b0));
        chk("t2_req_w2_blocked", 128'(mgr_req.req), 128'(1'b0));
        chk("t2_model_cnt", 128'(cnt_m), 128'(2));
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 32'd6, 32'h33, 4'd2, 0, 1); #2;
            chk("t3_rvalid_held", 128'(sbr_rsp.rvalid), 128'(1'b1));
            chk("t3_rid_held", 128'(sbr_rsp.r.rid), 128'(4'd0));
            chk("t3_rdata_held", 128'(sbr_rsp.r.rdata), 128'(32'd0));
            chk("t3_gnt_low", 128'(sbr_rsp.gnt), 128'(1'b0));
        end
        cyc(1, 1, 32'd6, 32'h33, 4'd2, 1, 1); #2;
        chk("t2_gnt_low_on_retire", 128'(sbr_rsp.gnt), 128'(1'b0));
        chk("t3_retire_rid0", 128'(sbr_rsp.r.rid), 128'(4'd0));
        cyc(1, 1, 32'd6, 32'h33, 4'd2, 0, 1); #2;
        chk("t2_gnt_w2_after", 128'(sbr_rsp.gnt), 128'(1'b1));
        chk("t3_head_rid1", 128'(sbr_rsp.r.rid), 128'(4'd1));
        repeat (4) cyc(0, 0, 32'd0, 32'd0, 4'd0, 1, 1);
        #2;
        chk("t2_model_drained", 128'(cnt_m), 128'(0));

        // T4: grant and retire in the same cycle at one outstanding
        cyc(1, 0, 32'd3, 32'd0, 4'd5, 0, 1);
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 0, 1);
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 0, 1); #2;
        chk("t4_model_cnt1", 128'(cnt_m), 128'(1));
        cyc(1, 0, 32'd7, 32'd0, 4'd6, 1, 1); #2;
        chk("t4_gnt", 128'(sbr_rsp.gnt), 128'(1'b1));
        chk("t4_rvalid", 128'(sbr_rsp.rvalid), 128'(1'b1));
        chk("t4_rid5", 128'(sbr_rsp.r.rid), 128'(4'd5));
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 0, 1); #2;
        chk("t4_model_cnt_still1", 128'(cnt_m), 128'(1));
        repeat (3) cyc(0, 0, 32'd0, 32'd0, 4'd0, 1, 1);

        // T5: asynchronous reset with two responses buffered
        cyc(1, 0, 32'd8, 32'd0, 4'd1, 0, 1);
        cyc(1, 0, 32'd9, 32'd0, 4'd2, 0, 1);
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 0, 1);
        cyc(0, 0, 32'd0, 32'd0, 4'd0, 0, 1); #2;
        chk("t5_pre_rvalid", 128'(sbr_rsp.rvalid), 128'(1'b1));
        chk("t5_pre_gnt_blocked", 128'(sbr_rsp.gnt), 128'(1'b0));
        rst_n = 1'b0;
        #1;
        chk("t5_async_rvalid", 128'(sbr_rsp.rvalid), 128'(1'b0));
        chk("t5_async_credit", 128'(sbr_rsp.gnt), 128'(1'b1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_v = 1'b0;
        got_r = '0;
        cyc(1, 0, 32'd2, 32'd0, 4'd7, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'd0, 32'd0, 4'd0, 1, 1); #2;
            if (sbr_rsp.rvalid) begin got_v = 1'b1; got_r = sbr_rsp.r; end
        end
        chk("t5_fresh_seen", 128'(got_v), 128'(1'b1));
        chk("t5_fresh_rdata", 128'(got_r.rdata), 128'(32'hCAFE0002));
        chk("t5_fresh_rid", 128'(got_r.rid), 128'(4'd7));

        // T6: random traffic against the SRAM model
        n_issued  = 0;
        n_retired = 0;
        rid_ctr   = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
                $urandom, rid_ctr, 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
            rid_ctr = rid_ctr + 4'd1;
        end
        repeat (8) cyc(0, 0, 32'd0, 32'd0, 4'd0, 1, 1);
        #2;
        chk("t6_drained_rvalid", 128'(sbr_rsp.rvalid), 128'(1'b0));
        chk("t6_none_lost", 128'(n_retired), 128'(n_issued));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
